// File: rtl/trace_checker.sv
// trace_checker: compares the processor's retired-write trace against a
// preloaded expected-trace buffer and reports a pass/fail verdict, the
// first failing entry and whether the failure came from an idle timeout.
module trace_checker #(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int MAX_IDLE = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_pc,
  input  logic [4:0]    load_waddr,
  input  logic [31:0]   load_wdata,
  input  logic [AW:0]   num_entries,
  input  logic          start,
  input  logic          clear,
  input  logic          trace_valid,
  input  logic [31:0]   trace_pc,
  input  logic [4:0]    trace_waddr,
  input  logic [31:0]   trace_wdata,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          timeout,
  output logic [AW-1:0] fail_idx,
  output logic [31:0]   fail_pc,
  output logic [AW:0]   match_count
);

  localparam int            IW        = $clog2(MAX_IDLE + 1);
  localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ZERO  = {(AW + 1){1'b0}};
  localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [IW-1:0] IDLE_ZERO = {IW{1'b0}};
  localparam logic [IW-1:0] IDLE_ONE  = {{(IW - 1){1'b0}}, 1'b1};
  localparam logic [IW-1:0] IDLE_LAST = IW'(MAX_IDLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } entry_t;

  entry_t          exp_mem_r [DEPTH];
  state_t          state_r;
  state_t          state_nxt_s;
  logic [AW:0]     target_r;
  logic [AW:0]     match_count_r;
  logic [IW-1:0]   idle_cnt_r;
  logic            busy_r;
  logic            done_r;
  logic            pass_r;
  logic            timeout_r;
  logic [AW-1:0]   fail_idx_r;
  logic [31:0]     fail_pc_r;
  logic            busy_s;
  logic            done_s;
  logic            pass_s;
  entry_t          entry_s;
  logic            fields_eq_s;
  logic            hit_s;
  logic            miss_s;
  logic            idle_expire_s;
  logic [AW:0]     count_inc_s;
  logic [AW:0]     clamp_s;

  // Match_count stays below the latched target while running, so the low
  // AW bits always address a valid entry.
  assign entry_s       = exp_mem_r[match_count_r[AW-1:0]];
  assign fields_eq_s   = (trace_pc == entry_s.pc) && (trace_waddr == entry_s.waddr) &&
                         (trace_wdata == entry_s.wdata);
  assign hit_s         = trace_valid && fields_eq_s;
  assign miss_s        = trace_valid && !fields_eq_s;
  assign idle_expire_s = !trace_valid && (idle_cnt_r == IDLE_LAST);
  assign count_inc_s   = match_count_r + CNT_ONE;
  assign clamp_s       = (num_entries > DEPTH_W) ? DEPTH_W : num_entries;

  assign busy        = busy_r;
  assign done        = done_r;
  assign pass        = pass_r;
  assign timeout     = timeout_r;
  assign fail_idx    = fail_idx_r;
  assign fail_pc     = fail_pc_r;
  assign match_count = match_count_r;

  // Expected-trace buffer: written only while idle, deliberately not reset.
  always_ff @(posedge clk) begin
    if ((state_r == ST_IDLE) && load_en) begin
      exp_mem_r[load_addr] <= '{pc: load_pc, waddr: load_waddr, wdata: load_wdata};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; clear has priority over start in the verdict states.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (clamp_s == CNT_ZERO) begin
            state_nxt_s = ST_PASS;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (hit_s && (count_inc_s == target_r)) begin
          state_nxt_s = ST_PASS;
        end else if (miss_s || idle_expire_s) begin
          state_nxt_s = ST_FAIL;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_PASS, ST_FAIL: begin
        if (clear) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Status flags decoded from the upcoming state so they register glitch-free.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    pass_s = 1'b0;
    case (state_nxt_s)
      ST_RUN: begin
        busy_s = 1'b1;
      end
      ST_PASS: begin
        done_s = 1'b1;
        pass_s = 1'b1;
      end
      ST_FAIL: begin
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Datapath: run target, match/idle counters and the failure record.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      pass_r        <= 1'b0;
      timeout_r     <= 1'b0;
      fail_idx_r    <= {AW{1'b0}};
      fail_pc_r     <= 32'd0;
      match_count_r <= CNT_ZERO;
      target_r      <= CNT_ZERO;
      idle_cnt_r    <= IDLE_ZERO;
    end else begin
      busy_r <= busy_s;
      done_r <= done_s;
      pass_r <= pass_s;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            target_r      <= clamp_s;
            match_count_r <= CNT_ZERO;
            idle_cnt_r    <= IDLE_ZERO;
          end
        end
        ST_RUN: begin
          if (trace_valid) begin
            idle_cnt_r <= IDLE_ZERO;
            if (fields_eq_s) begin
              match_count_r <= count_inc_s;
            end else begin
              fail_idx_r <= match_count_r[AW-1:0];
              fail_pc_r  <= trace_pc;
            end
          end else if (idle_expire_s) begin
            timeout_r  <= 1'b1;
            fail_idx_r <= match_count_r[AW-1:0];
            fail_pc_r  <= 32'd0;
          end else begin
            idle_cnt_r <= idle_cnt_r + IDLE_ONE;
          end
        end
        ST_PASS, ST_FAIL: begin
          if (clear) begin
            match_count_r <= CNT_ZERO;
            timeout_r     <= 1'b0;
          end
        end
        default: begin
          idle_cnt_r <= IDLE_ZERO;
        end
      endcase
    end
  end

endmodule

// File: doc/trace_checker.md
Name: trace_checker

Overview:
- Hardware self-check block that consumes the processor's per-cycle debug trace: PC, register-file write address/data, and data-memory in/out.
- Compares the trace against an expected-trace buffer preloaded through a write port, then reports pass/fail with the failing entry.
- Sits beside top in on-board/FPGA builds so a program run produces a verdict without a waveform viewer.

Parameters:
- DEPTH, 16, number of expected-trace entries stored.
- AW, 4, entry index width; DEPTH = 2**AW.
- MAX_IDLE, 64, cycles without trace_valid in RUN before a timeout failure.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- load_en  in  1  write one expected entry; honoured in IDLE only.
- load_addr  in  AW  entry index to write.
- load_pc  in  32  expected PC.
- load_waddr  in  5  expected destination register (Rd or Rt).
- load_wdata  in  32  expected register write data.
- num_entries  in  AW+1  entries to check; sampled on start.
- start  in  1  one-cycle pulse; IDLE -> RUN.
- clear  in  1  PASS/FAIL -> IDLE.
- trace_valid  in  1  trace inputs carry a retired write this cycle.
- trace_pc  in  32  observed PC.
- trace_waddr  in  5  observed RdOrRt.
- trace_wdata  in  32  observed WriteData.
- busy  out  1  high in RUN.
- done  out  1  high in PASS or FAIL.
- pass  out  1  high in PASS only.
- timeout  out  1  FAIL was caused by the idle timeout.
- fail_idx  out  AW  index of the first mismatching entry.
- fail_pc  out  32  observed PC at the mismatch (0 on timeout).
- match_count  out  AW+1  entries matched so far.

Behaviour:
- Reset:
  - State goes to IDLE.
  - busy, done, pass, timeout = 0; fail_idx = 0; fail_pc = 0; match_count = 0; idle counter = 0.
  - Buffer contents are not reset, so reset mid-RUN aborts the check and keeps the loaded entries.
- States:
  - IDLE: load_en writes {pc, waddr, wdata} to buffer[load_addr] at the clock edge. On start, latch num_entries and clear match_count. If the latched count is 0, go to PASS; otherwise go to RUN.
  - RUN: load_en and start are ignored. Each cycle with trace_valid compares all three trace fields against buffer[match_count] and resets the idle counter.
    - All fields equal: increment match_count. If the new count equals the latched num_entries, go to PASS.
    - Any field differs: latch fail_idx = match_count and fail_pc = trace_pc, then go to FAIL.
    - A cycle without trace_valid increments the idle counter. When it reaches MAX_IDLE, go to FAIL with timeout = 1, fail_idx = match_count and fail_pc = 0.
  - PASS/FAIL: hold all outputs. start is ignored. clear returns to IDLE, keeping the buffer and zeroing done, pass, timeout and match_count.
- Latency: the verdict from a trace_valid at edge n is visible on outputs after edge n+1. busy drops in the same cycle that done rises.
- Simultaneous events:
  - load_en with start in IDLE: the write completes and the run starts; the written entry is usable as entry 0 if load_addr = 0.
  - clear with start in PASS/FAIL: clear wins and the state becomes IDLE.
  - A mismatch and a timeout cannot coincide, because trace_valid resets the idle counter.
  - trace_valid after PASS/FAIL is ignored.
- num_entries > DEPTH is clamped to DEPTH at latch time.
- match_count never wraps: the RUN exit occurs at equality before any overflow.

Test Plan:
1. Load 3 entries: (PC 0x0, r8, 5), (PC 0x4, r9, 7), (PC 0x8, r10, 12). Set num_entries = 3, pulse start, drive three matching trace_valid cycles. Required: pass = 1 and done = 1 one cycle after the third trace; match_count = 3; busy low afterwards.
2. Same load, with wdata 13 on the third trace. Required: FAIL, fail_idx = 2, fail_pc = 0x8, timeout = 0, pass = 0, match_count = 2.
3. Start with num_entries = 2, one matching trace, then no trace_valid. Required: after exactly MAX_IDLE = 64 idle cycles, done = 1, timeout = 1, fail_idx = 1, fail_pc = 0.
4. Start with num_entries = 0. Required: PASS on the next cycle, match_count = 0, and busy never asserted.
5. Assert reset mid-RUN after 1 match, then start again with the same 3 entries and a fully matching trace. Required: after reset all outputs are 0 and the state is IDLE; the rerun passes, proving the buffer was retained.
6. In PASS, drive start and clear together. Required: IDLE with done = 0. Then load_en during RUN with a different value at index 0: the write is ignored, and a rerun still matches the original entry 0.
